// File: rtl/dmem_arbiter.sv
// Data RAM front end: round-robin CPU/debug arbitration, sub-word
// read-modify-write stores, load extension and misalignment errors.
module dmem_arbiter #(
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_size,
  input  logic        cpu_unsigned,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ready,
  output logic [31:0] cpu_rdata,
  output logic        cpu_err,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_ready,
  output logic [31:0] dbg_rdata,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_din,
  input  logic [31:0] ram_dout
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t            state;
  logic              g_dbg;
  logic              we;
  logic              uns;
  logic              prio_dbg;
  logic [1:0]        size;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       data;

  logic              pick_dbg;
  logic              n_we;
  logic              n_err;
  logic [1:0]        n_size;
  logic [ADDR_W-1:0] n_addr;
  logic [31:0]       n_wdata;
  logic              unused;

  function automatic logic bad_align(logic [1:0] sz, logic [1:0] a);
    logic r;
    r = 1'b1;
    unique case (sz)
      2'b00:   r = 1'b0;
      2'b01:   r = a[0];
      2'b10:   r = |a;
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge(
    logic [31:0] old, logic [31:0] wd,
    logic [1:0] sz, logic [1:0] a);
    logic [31:0] r;
    r = old;
    unique case (1'b1)
      sz == 2'b00: r[8*a +: 8] = wd[7:0];
      sz == 2'b01: r[16*a[1] +: 16] = wd[15:0];
      default:     r = wd;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] extend(
    logic [31:0] w, logic [1:0] sz,
    logic u, logic [1:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[8*a +: 8];
    h = w[16*a[1] +: 16];
    r = w;
    unique case (1'b1)
      sz == 2'b00: r = {{24{~u & b[7]}}, b};
      sz == 2'b01: r = {{16{~u & h[15]}}, h};
      default:     r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] word_addr(logic [ADDR_W-1:0] a);
    return {{(32-ADDR_W){1'b0}}, a[ADDR_W-1:2], 2'b00};
  endfunction

  // Debug wins a tie only when the CPU took the previous grant
  assign pick_dbg = dbg_req & (~cpu_req | prio_dbg);
  assign n_we     = pick_dbg ? dbg_we : cpu_we;
  assign n_size   = pick_dbg ? 2'b10 : cpu_size;
  assign n_wdata  = pick_dbg ? dbg_wdata : cpu_wdata;
  assign n_addr   = pick_dbg ? {dbg_addr[ADDR_W-1:2], 2'b00}
                             : cpu_addr[ADDR_W-1:0];
  assign n_err    = ~pick_dbg & bad_align(cpu_size, cpu_addr[1:0]);
  assign unused   = ^{cpu_addr[31:ADDR_W], dbg_addr[31:ADDR_W],
                      dbg_addr[1:0]};
  assign ram_din  = data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      g_dbg     <= 1'b0;
      we        <= 1'b0;
      uns       <= 1'b0;
      prio_dbg  <= 1'b0;
      size      <= 2'b00;
      addr      <= '0;
      wdata     <= '0;
      data      <= '0;
      cpu_ready <= 1'b0;
      cpu_rdata <= '0;
      cpu_err   <= 1'b0;
      dbg_ready <= 1'b0;
      dbg_rdata <= '0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
    end else begin
      cpu_ready <= 1'b0;
      dbg_ready <= 1'b0;
      ram_we    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cpu_req | dbg_req) begin
            g_dbg    <= pick_dbg;
            we       <= n_we;
            size     <= n_size;
            uns      <= ~pick_dbg & cpu_unsigned;
            addr     <= n_addr;
            wdata    <= n_wdata;
            ram_addr <= word_addr(n_addr);
            if (n_err) begin
              state     <= DONE;
              cpu_ready <= 1'b1;
              cpu_err   <= 1'b1;
              cpu_rdata <= '0;
            end else if (n_we && n_size == 2'b10) begin
              state  <= WR;
              ram_we <= 1'b1;
              data   <= n_wdata;
            end else begin
              state <= RD;
            end
          end
        end
        RD: begin
          data <= we ? merge(ram_dout, wdata, size, addr[1:0])
                     : ram_dout;
          if (we) begin
            state  <= WR;
            ram_we <= 1'b1;
          end else begin
            state <= DONE;
            if (g_dbg) begin
              dbg_ready <= 1'b1;
              dbg_rdata <= ram_dout;
            end else begin
              cpu_ready <= 1'b1;
              cpu_err   <= 1'b0;
              cpu_rdata <= extend(ram_dout, size, uns, addr[1:0]);
            end
          end
        end
        WR: begin
          state <= DONE;
          if (g_dbg) begin
            dbg_ready <= 1'b1;
            dbg_rdata <= '0;
          end else begin
            cpu_ready <= 1'b1;
            cpu_err   <= 1'b0;
            cpu_rdata <= '0;
          end
        end
        DONE: begin
          state    <= IDLE;
          ram_addr <= '0;
          prio_dbg <= ~g_dbg;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, reset/arbitration
// sequences and randomized traffic against a word-array reference model.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, cpu_unsigned;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_ready, cpu_err;
  logic [31:0] cpu_rdata;
  logic        dbg_req, dbg_we;
  logic [31:0] dbg_addr, dbg_wdata;
  logic        dbg_ready;
  logic [31:0] dbg_rdata;
  logic        ram_we;
  logic [31:0] ram_addr, ram_din, ram_dout;

  dmem_arbiter #(.ADDR_W(10)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size),
    .cpu_unsigned(cpu_unsigned), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready),
    .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_ready(dbg_ready),
    .dbg_rdata(dbg_rdata), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // 1 KB RAM: combinational read, synchronous write
  logic [31:0] ram [256];
  assign ram_dout = ram[ram_addr[9:2]];
  always @(posedge clk) if (ram_we) ram[ram_addr[9:2]] <= ram_din;

  logic [31:0] rmem [256];
  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic bit m_bad(int sz, int a);
    return sz == 3 || (sz == 1 && a % 2 == 1) || (sz == 2 && a % 4 != 0);
  endfunction

  function automatic logic [31:0] m_load(logic [31:0] w, int sz,
                                         bit u, int off);
    longint v;
    if (sz == 2) return w;
    if (sz == 0) begin
      v = (longint'(w) >> (8 * off)) % 256;
      if (!u && v >= 128) v -= 256;
    end else begin
      v = (longint'(w) >> (16 * (off / 2))) % 65536;
      if (!u && v >= 32768) v -= 65536;
    end
    return v[31:0];
  endfunction

  function automatic logic [31:0] m_store(logic [31:0] old,
                                          logic [31:0] wd, int sz, int off);
    longint m, s;
    logic [31:0] mm;
    if (sz == 2) return wd;
    if (sz == 0) begin
      m = longint'(255) << (8 * off);
      s = longint'(wd % 256) << (8 * off);
    end else begin
      m = longint'(65535) << (16 * (off / 2));
      s = longint'(wd % 65536) << (16 * (off / 2));
    end
    mm = m[31:0];
    return (old & ~mm) | s[31:0];
  endfunction

  logic [31:0] t_rd, t_din;
  bit          t_er;
  int          t_rc, t_wen, t_wec;

  // Starts in IDLE just after a rising edge; returns in IDLE likewise
  task automatic txn(input bit d, input bit w, input logic [1:0] sz,
                     input bit u, input logic [31:0] a, wd);
    t_rc = -1; t_wen = 0; t_wec = -1; t_rd = '0; t_er = 0; t_din = '0;
    if (d) begin
      dbg_req = 1; dbg_we = w; dbg_addr = a; dbg_wdata = wd;
    end else begin
      cpu_req = 1; cpu_we = w; cpu_size = sz; cpu_unsigned = u;
      cpu_addr = a; cpu_wdata = wd;
    end
    for (int n = 1; n <= 8 && t_rc < 0; n++) begin
      @(posedge clk); #1;
      if (ram_we) begin t_wen++; t_wec = n; t_din = ram_din; end
      if (d ? dbg_ready : cpu_ready) begin
        t_rc = n;
        t_rd = d ? dbg_rdata : cpu_rdata;
        t_er = d ? 1'b0 : cpu_err;
      end
    end
    cpu_req = 0; dbg_req = 0;
    @(posedge clk); #1;
    if (t_rc >= 0) chk("ready_width", {31'b0, d ? dbg_ready : cpu_ready}, 0);
  endtask

  typedef struct {
    bit          we;
    logic [1:0]  sz;
    bit          u;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    bit          err;
    int          rc;
    int          wc;
    logic [31:0] din;
  } vec_t;

  vec_t vt [16];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) begin ram[i] = '0; rmem[i] = '0; end
    rst = 1; cpu_req = 0; cpu_we = 0; cpu_size = 0; cpu_unsigned = 0;
    cpu_addr = 0; cpu_wdata = 0; dbg_req = 0; dbg_we = 0;
    dbg_addr = 0; dbg_wdata = 0;

    vt[0]  = '{1, 2'b10, 0, 32'h100, 32'h12345678, 0, 0, 2, 1, 32'h12345678};
    vt[1]  = '{0, 2'b10, 0, 32'h100, 0, 32'h12345678, 0, 2, -1, 0};
    vt[2]  = '{1, 2'b10, 0, 32'h104, 32'hAABBCCDD, 0, 0, 2, 1, 32'hAABBCCDD};
    vt[3]  = '{1, 2'b00, 0, 32'h106, 32'h00000055, 0, 0, 3, 2, 32'hAA55CCDD};
    vt[4]  = '{0, 2'b10, 0, 32'h104, 0, 32'hAA55CCDD, 0, 2, -1, 0};
    vt[5]  = '{1, 2'b10, 0, 32'h108, 32'h0000F080, 0, 0, 2, 1, 32'h0000F080};
    vt[6]  = '{0, 2'b00, 0, 32'h108, 0, 32'hFFFFFF80, 0, 2, -1, 0};
    vt[7]  = '{0, 2'b00, 1, 32'h108, 0, 32'h00000080, 0, 2, -1, 0};
    vt[8]  = '{0, 2'b01, 0, 32'h108, 0, 32'hFFFFF080, 0, 2, -1, 0};
    vt[9]  = '{0, 2'b01, 1, 32'h10A, 0, 32'h00000000, 0, 2, -1, 0};
    vt[10] = '{0, 2'b01, 0, 32'h101, 0, 32'h00000000, 1, 1, -1, 0};
    vt[11] = '{1, 2'b10, 0, 32'h102, 32'hDEADBEEF, 0, 1, 1, -1, 0};
    vt[12] = '{0, 2'b10, 0, 32'h100, 0, 32'h12345678, 0, 2, -1, 0};
    vt[13] = '{1, 2'b01, 0, 32'h10A, 32'h1234BEEF, 0, 0, 3, 2, 32'hBEEFF080};
    vt[14] = '{0, 2'b01, 0, 32'h10A, 0, 32'hFFFFBEEF, 0, 2, -1, 0};
    vt[15] = '{0, 2'b11, 0, 32'h10C, 0, 32'h00000000, 1, 1, -1, 0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctl", {28'b0, cpu_ready, cpu_err, dbg_ready, ram_we}, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_dbg_rdata", dbg_rdata, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_din", ram_din, 0);
    rst = 0;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) begin
      txn(0, vt[i].we, vt[i].sz, vt[i].u, vt[i].a, vt[i].wd);
      chk($sformatf("vec%0d_ready_cycle", i), t_rc, vt[i].rc);
      chk($sformatf("vec%0d_err", i), {31'b0, t_er}, {31'b0, vt[i].err});
      chk($sformatf("vec%0d_we_cycle", i), t_wec, vt[i].wc);
      chk($sformatf("vec%0d_we_count", i), t_wen, vt[i].wc < 0 ? 0 : 1);
      if (!vt[i].we || vt[i].err)
        chk($sformatf("vec%0d_rdata", i), t_rd, vt[i].rd);
      if (vt[i].wc >= 0)
        chk($sformatf("vec%0d_din", i), t_din, vt[i].din);
      chk($sformatf("vec%0d_idle_addr", i), ram_addr, 0);
    end

    // Reset while a byte store is in its write cycle
    begin
      bit seen;
      seen = 0;
      cpu_req = 1; cpu_we = 1; cpu_size = 2'b00; cpu_unsigned = 0;
      cpu_addr = 32'h104; cpu_wdata = 32'h77;
      for (int n = 1; n <= 5 && !seen; n++) begin
        @(posedge clk); #1;
        if (ram_we) seen = 1;
      end
      chk("rst_wr_we_seen", {31'b0, seen}, 1);
      rst = 1; #1;
      chk("rst_wr_ram_we", {31'b0, ram_we}, 0);
      chk("rst_wr_ctl", {29'b0, cpu_ready, cpu_err, dbg_ready}, 0);
      chk("rst_wr_cpu_rdata", cpu_rdata, 0);
      chk("rst_wr_ram_addr", ram_addr, 0);
      chk("rst_wr_ram_din", ram_din, 0);
      cpu_req = 0;
      for (int n = 0; n < 2; n++) begin
        @(posedge clk); #1;
        chk("rst_wr_no_ready", {31'b0, cpu_ready}, 0);
      end
      rst = 0;
      @(posedge clk); #1;
    end

    // Both ports held high: CPU first after reset, then strict alternation
    begin
      int cnt, last;
      bit prev;
      cnt = 0; last = 0; prev = 0;
      cpu_req = 1; cpu_we = 0; cpu_size = 2'b10; cpu_unsigned = 0;
      cpu_addr = 32'h100;
      dbg_req = 1; dbg_we = 0; dbg_addr = 32'h107;
      for (int n = 1; n <= 30 && cnt < 4; n++) begin
        @(posedge clk); #1;
        if (cpu_ready || dbg_ready) begin
          chk("arb_both_ready", {31'b0, cpu_ready & dbg_ready}, 0);
          chk($sformatf("arb_grant%0d", cnt), {31'b0, dbg_ready},
              cnt % 2);
          chk($sformatf("arb_rdata%0d", cnt),
              dbg_ready ? dbg_rdata : cpu_rdata,
              cnt % 2 ? 32'hAA55CCDD : 32'h12345678);
          chk("arb_width", {31'b0, prev}, 0);
          if (cnt > 0) chk("arb_spacing", n - last, 3);
          else chk("arb_first_cycle", n, 2);
          last = n;
          cnt++;
          if (cnt == 4) begin cpu_req = 0; dbg_req = 0; end
        end
        prev = cpu_ready | dbg_ready;
      end
      chk("arb_count", cnt, 4);
      @(posedge clk); #1;
    end

    // Random traffic in the low 256 bytes, random upper address bits
    for (int i = 0; i < 300; i++) begin
      bit d, w, u, bad;
      int sz, off, idx, erc;
      logic [31:0] a, wd, erd;
      d   = ($urandom_range(0, 3) == 0);
      w   = $urandom_range(0, 1);
      sz  = d ? 2 : $urandom_range(0, 3);
      u   = $urandom_range(0, 1);
      a   = ($urandom & 32'hFFFF_FC00) | $urandom_range(0, 255);
      wd  = $urandom;
      idx = (a % 1024) / 4;
      off = a % 4;
      bad = !d && m_bad(sz, off);
      erc = bad ? 1 : (w && !d && sz != 2) ? 3 : 2;
      erd = bad ? 32'h0 : m_load(rmem[idx], d ? 2 : sz, u, d ? 0 : off);
      txn(d, w, sz[1:0], u, a, wd);
      chk("rnd_ready_cycle", t_rc, erc);
      chk("rnd_err", {31'b0, t_er}, {31'b0, bad});
      chk("rnd_we_count", t_wen, (w && !bad) ? 1 : 0);
      if (!w || bad) chk("rnd_rdata", t_rd, erd);
      if (w && !bad) rmem[idx] = m_store(rmem[idx], wd, sz, off);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Controller that sits in front of the word-only, single-port data RAM (1 KB, combinational read, synchronous write) and shares it between the CPU MEM-stage load/store port and a word-wide debug/loader port. It arbitrates round-robin, sequences each granted transaction through a small FSM, and performs read-modify-write for byte and halfword stores. It also extracts and sign- or zero-extends sub-word loads and flags misaligned CPU accesses.

## Interface
- ADDR_W, 10: byte-address bits that reach the RAM; higher address bits are ignored, so addresses wrap modulo 2^ADDR_W.
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- cpu_req  in  1  CPU request; held until cpu_ready
- cpu_we  in  1  1 = store, 0 = load
- cpu_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- cpu_unsigned  in  1  zero-extend sub-word load (LBU/LHU)
- cpu_addr  in  32  byte address
- cpu_wdata  in  32  store data, in low lanes
- cpu_ready  out  1  one-cycle completion pulse
- cpu_rdata  out  32  extended load data, valid with cpu_ready
- cpu_err  out  1  misaligned/illegal, valid with cpu_ready
- dbg_req  in  1  debug request, word only; held until dbg_ready
- dbg_we  in  1  1 = store
- dbg_addr  in  32  byte address, addr[1:0] ignored
- dbg_wdata  in  32  store word
- dbg_ready  out  1  one-cycle completion pulse
- dbg_rdata  out  32  load word, valid with dbg_ready
- ram_we  out  1  RAM write enable
- ram_addr  out  32  word-aligned address {addr[31:2],2'b00}
- ram_din  out  32  RAM write data
- ram_dout  in  32  RAM combinational read data

## Operation
- States: IDLE, RD, WR, DONE.
- IDLE: sample requests. If exactly one req is high, grant it. If both are high, grant the port that did not win last (round-robin). Latch the grantee, we, size, unsigned, addr and wdata.
- Transitions out of IDLE:
  - Word load or any debug load -> RD.
  - Word store or debug store -> WR.
  - CPU sub-word store -> RD, then WR.
  - CPU misaligned access -> DONE with err. Misaligned means: half with addr[0]=1; word with addr[1:0]!=0; or size 11.
- RD: capture ram_dout into the data register. Then go to WR for a store, or DONE for a load.
- WR: ram_we=1. ram_din is the captured word with the addressed lane(s) replaced by wdata[7:0] (byte lane addr[1:0]) or wdata[15:0] (half lane addr[1]), or the full wdata for word stores. Go to DONE.
- DONE: pulse the grantee's ready for one cycle, update the round-robin pointer, then return to IDLE.
- Load extension:
  - Byte: lane addr[1:0].
  - Half: lane addr[1].
  - Bit 7 or bit 15 is replicated when unsigned=0; zeros are filled when unsigned=1.
- Error access: no RAM write occurs; cpu_rdata=0.
- The non-granted requester waits; its req is not dropped or acknowledged.
- ram_addr is driven from the latched address in all non-IDLE states, and is 0 in IDLE.

## Timing
- Reset state (asynchronous): state=IDLE, round-robin pointer favours CPU, data register=0. All outputs are 0: ready, err, rdata, ram_we, ram_addr, ram_din.
- Cycle 0 is the IDLE cycle in which req is sampled high. Ready is high in:
  - cycle 2 for a load or word store;
  - cycle 3 for a sub-word store;
  - cycle 1 for an error.
- rdata and err are registered and held until the next DONE of that port.
- If a requester still has req high in the cycle after its ready, that is a new transaction. Back-to-back throughput is one word op per 3 cycles.
- Reset mid-transaction: ram_we falls immediately, no ready is issued, and the transaction is discarded.
- Simultaneous requests: strict alternation while both remain high.

## Test plan
- CPU SW 0x12345678 @0x100, then LW @0x100 -> ram_we in cycle 1 only; ready in cycle 2; rdata=0x12345678.
- Word 0xAABBCCDD at 0x104, SB 0x55 @0x106 -> RD, then WR with ram_din=0xAA55CCDD; ready in cycle 3.
- Word 0x0000F080 at 0x108: LB @0x108 -> 0xFFFFFF80; LBU -> 0x00000080; LH -> 0xFFFFF080; LHU @0x10A -> 0x00000000.
- LH @0x101 and SW @0x102 -> err=1 in cycle 1; ram_we never asserts; memory is unchanged.
- cpu_req and dbg_req held high together for 4 transactions -> grants alternate CPU, DBG, CPU, DBG; every ready is one cycle wide.
- Assert rst during WR of a sub-word store -> ram_we drops the same cycle; no ready; all outputs return to 0.
